uart_tx_fifo: RTL and testbench

Parameterised UART transmitter with an integrated transmit FIFO. It is the successor to the fixed 8-bit, single-buffer transmit path of the UART. It adds configurable data width, FIFO depth and clock frequency, selectable 1 or 2 stop bits, and back-to-back frame streaming. It sits between the host-side write interface and the serial `tx` line, and runs off the 50 MHz system clock.

---
 rtl/uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// UART transmitter fed by a registered first-word-fall-through FIFO.
// Define UART_TX_BREAK_EN to add the break_req port and line-break generator.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        parity_type,
    input  logic [1:0]        baud_rate,
    input  logic              stop_bits,
`ifdef UART_TX_BREAK_EN
    input  logic              break_req,
`endif
    output logic              tx,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic              tx_active_flag,
    output logic              tx_done_flag
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLK_FREQ / 2400 + 1);
    localparam int BIT_W = 5;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] S_BREAK  = 3'd5;
    localparam logic [2:0] S_BRK_END = 3'd6;
`endif

    function automatic logic [CNT_W-1:0] div_of(input logic [1:0] sel);
        case (sel)
            2'b00:   div_of = CNT_W'(CLK_FREQ / 2400);
            2'b01:   div_of = CNT_W'(CLK_FREQ / 4800);
            2'b10:   div_of = CNT_W'(CLK_FREQ / 9600);
            default: div_of = CNT_W'(CLK_FREQ / 19200);
        endcase
    endfunction

`ifdef UART_TX_BREAK_EN
    function automatic logic [BIT_W-1:0] frame_bits(input logic [1:0] pt, input logic sb);
        frame_bits = BIT_W'(DATA_W + 2) + BIT_W'(pt == 2'b01 || pt == 2'b10) + BIT_W'(sb);
    endfunction
`endif

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg, level_next;
    logic              full_reg, empty_reg, overflow_reg;
    logic              push, pop;
    logic [DATA_W-1:0] head;

    assign push       = wr_en && !full_reg;
    assign head       = mem[rd_ptr_reg];
    assign level_next = level_reg + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            level_reg    <= level_next;
            full_reg     <= (level_next == LVL_W'(FIFO_DEPTH));
            empty_reg    <= (level_next == '0);
            overflow_reg <= wr_en && full_reg;
        end
    end

    // Transmit FSM; per-frame settings are latched at the pop
    logic [2:0]        state_reg, state_next;
    logic [CNT_W-1:0]  baud_cnt_reg, baud_cnt_next;
    logic [CNT_W-1:0]  div_reg, div_next;
    logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              par_en_reg, par_en_next;
    logic              par_bit_reg, par_bit_next;
    logic              two_stop_reg, two_stop_next;
    logic              tx_reg, tx_next;
    logic              bit_end, last_stop;
`ifdef UART_TX_BREAK_EN
    logic [BIT_W-1:0]  brk_len_reg, brk_len_next;
`endif

    assign bit_end   = (baud_cnt_reg == div_reg - 1'b1);
    assign last_stop = (bit_cnt_reg == BIT_W'(two_stop_reg));

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;
        div_next      = div_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        par_en_next   = par_en_reg;
        par_bit_next  = par_bit_reg;
        two_stop_next = two_stop_reg;
        pop           = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_len_next  = brk_len_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                baud_cnt_next = '0;
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_next   = S_BREAK;
                    div_next     = div_of(baud_rate);
                    bit_cnt_next = '0;
                    brk_len_next = frame_bits(parity_type, stop_bits) << 1;
                end else
`endif
                if (!empty_reg) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next   = S_DATA;
                    bit_cnt_next = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = par_en_reg ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next   = S_STOP;
                    bit_cnt_next = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        if (!empty_reg) pop = 1'b1;
                        else            state_next = S_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            // Low for the programmed length, then stretched while break_req stays high
            S_BREAK: begin
                if (bit_cnt_reg == brk_len_reg) begin
                    baud_cnt_next = '0;
                    if (!break_req) state_next = S_BRK_END;
                end else if (bit_end) begin
                    if (bit_cnt_reg == brk_len_reg - 1'b1 && !break_req) state_next = S_BRK_END;
                    else bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            S_BRK_END: begin
                if (bit_end) state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase

        if (pop) begin
            state_next    = S_START;
            baud_cnt_next = '0;
            bit_cnt_next  = '0;
            shift_next    = head;
            div_next      = div_of(baud_rate);
            par_en_next   = (parity_type == 2'b01) || (parity_type == 2'b10);
            par_bit_next  = (parity_type == 2'b01) ? ~^head : ^head;
            two_stop_next = stop_bits;
        end

        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = par_bit_next;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  tx_next = 1'b0;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            div_reg      <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
            two_stop_reg <= 1'b0;
            tx_reg       <= 1'b1;
`ifdef UART_TX_BREAK_EN
            brk_len_reg  <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            div_reg      <= div_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            par_en_reg   <= par_en_next;
            par_bit_reg  <= par_bit_next;
            two_stop_reg <= two_stop_next;
            tx_reg       <= tx_next;
`ifdef UART_TX_BREAK_EN
            brk_len_reg  <= brk_len_next;
`endif
        end
    end

    assign tx             = tx_reg;
    assign full           = full_reg;
    assign empty          = empty_reg;
    assign level          = level_reg;
    assign overflow       = overflow_reg;
    assign tx_active_flag = (state_reg == S_START) || (state_reg == S_DATA) ||
                            (state_reg == S_PARITY) || (state_reg == S_STOP);
    assign tx_done_flag   = (state_reg == S_STOP) && bit_end && last_stop;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Randomised self-checking bench for uart_tx_fifo; a scaled clock keeps the
// baud divisors small (80/40/20/10) while preserving the frame arithmetic.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 192_000;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int LVL_W    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        parity_type;
    logic [1:0]        baud_rate;
    logic              stop_bits;
`ifdef UART_TX_BREAK_EN
    logic              break_req;
`endif
    logic              tx, full, empty, overflow, tx_active_flag, tx_done_flag;
    logic [LVL_W-1:0]  level;

    int vectors;
    int miscompares;

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .parity_type(parity_type), .baud_rate(baud_rate), .stop_bits(stop_bits),
`ifdef UART_TX_BREAK_EN
        .break_req(break_req),
`endif
        .tx(tx), .full(full), .empty(empty), .level(level), .overflow(overflow),
        .tx_active_flag(tx_active_flag), .tx_done_flag(tx_done_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic int div_for(input logic [1:0] b);
        case (b)
            2'b00:   return CLK_FREQ / 2400;
            2'b01:   return CLK_FREQ / 4800;
            2'b10:   return CLK_FREQ / 9600;
            default: return CLK_FREQ / 19200;
        endcase
    endfunction

    task automatic write_word(input logic [DATA_W-1:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int bound);
        int n = 0;
        while (tx !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL %s start_timeout: tx=%b after %0d cycles, expected start bit 0", tag, tx, n);
        end
    endtask

    // Called on the first start-bit cycle; returns on the cycle after the last stop bit.
    task automatic expect_frame(input logic [DATA_W-1:0] d, input logic [1:0] pt,
                                input logic st, input int div, input string tag);
        logic bits[$];
        int   ones, done_cnt, done_at, k;
        logic ok, bad_tx, bad_act;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
        ones = $countones(d);
        if (pt == 2'b10)      bits.push_back(ones % 2 == 1);
        else if (pt == 2'b01) bits.push_back(ones % 2 == 0);
        bits.push_back(1'b1);
        if (st) bits.push_back(1'b1);
        done_cnt = 0;
        done_at  = -1;
        k        = 0;
        for (int b = 0; b < bits.size(); b++) begin
            ok = 1'b1; bad_tx = 1'b0; bad_act = 1'b0;
            for (int c = 0; c < div; c++) begin
                if (ok && (tx !== bits[b] || tx_active_flag !== 1'b1)) begin
                    ok = 1'b0; bad_tx = tx; bad_act = tx_active_flag;
                end
                if (tx_done_flag === 1'b1) begin
                    done_cnt++;
                    done_at = k;
                end
                k++;
                @(negedge clk);
            end
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL %s bit%0d: tx=%b active=%b, expected tx=%b active=1",
                         tag, b, bad_tx, bad_act, bits[b]);
            end
        end
        vectors++;
        if (done_cnt != 1 || done_at != k - 1) begin
            miscompares++;
            $display("FAIL %s done_pulse: %0d pulses last at cycle %0d, expected 1 pulse at cycle %0d",
                     tag, done_cnt, done_at, k - 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (tx !== 1'b1)             begin miscompares++; $display("FAIL reset_tx: %b, expected 1", tx); end
        vectors++; if (empty !== 1'b1)          begin miscompares++; $display("FAIL reset_empty: %b, expected 1", empty); end
        vectors++; if (full !== 1'b0)           begin miscompares++; $display("FAIL reset_full: %b, expected 0", full); end
        vectors++; if (level !== '0)            begin miscompares++; $display("FAIL reset_level: %0d, expected 0", level); end
        vectors++; if (overflow !== 1'b0)       begin miscompares++; $display("FAIL reset_overflow: %b, expected 0", overflow); end
        vectors++; if (tx_active_flag !== 1'b0) begin miscompares++; $display("FAIL reset_active: %b, expected 0", tx_active_flag); end
        vectors++; if (tx_done_flag !== 1'b0)   begin miscompares++; $display("FAIL reset_done: %b, expected 0", tx_done_flag); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || empty !== 1'b1 || tx_active_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: tx=%b empty=%b active=%b, expected 1 1 0", tx, empty, tx_active_flag);
        end
    endtask

    task automatic test_single_frame();
        parity_type = 2'b01; baud_rate = 2'b10; stop_bits = 1'b0;
        write_word(8'hAA);
        vectors++;
        if (level !== LVL_W'(1) || empty !== 1'b0 || tx !== 1'b1 || tx_active_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_n1: level=%0d empty=%b tx=%b active=%b, expected 1 0 1 0",
                     level, empty, tx, tx_active_flag);
        end
        @(negedge clk);
        vectors++;
        if (level !== '0 || empty !== 1'b1 || tx !== 1'b0 || tx_active_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_n2: level=%0d empty=%b tx=%b active=%b, expected 0 1 0 1",
                     level, empty, tx, tx_active_flag);
        end
        expect_frame(8'hAA, 2'b01, 1'b0, div_for(2'b10), "aa_odd");
        vectors++;
        if (tx !== 1'b1 || tx_active_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL aa_idle_after: tx=%b active=%b, expected 1 0", tx, tx_active_flag);
        end
    endtask

    task automatic test_random_frames();
        logic [DATA_W-1:0] d;
        logic [1:0] pt, br;
        logic st;
        for (int i = 0; i < 6; i++) begin
            d = DATA_W'($urandom); pt = 2'($urandom); br = 2'($urandom); st = 1'($urandom);
            parity_type = pt; baud_rate = br; stop_bits = st;
            write_word(d);
            wait_start($sformatf("rand%0d", i), 8);
            // Settings were latched at the pop; scrambling them must not affect this frame
            parity_type = 2'($urandom); baud_rate = 2'($urandom); stop_bits = 1'($urandom);
            expect_frame(d, pt, st, div_for(br), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] w [5];
        logic [1:0] pt, br;
        logic st;
        parity_type = 2'b10; baud_rate = 2'b11; stop_bits = 1'b1;
        write_word(8'h5C);
        write_word(8'hA3);
        wait_start("b2b", 8);
        expect_frame(8'h5C, 2'b10, 1'b1, div_for(2'b11), "b2b_5c");
        expect_frame(8'hA3, 2'b10, 1'b1, div_for(2'b11), "b2b_a3");
        vectors++;
        if (tx !== 1'b1 || tx_active_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle_after: tx=%b active=%b, expected 1 0", tx, tx_active_flag);
        end
        pt = 2'($urandom); br = 2'($urandom_range(1, 3)); st = 1'($urandom);
        parity_type = pt; baud_rate = br; stop_bits = st;
        for (int i = 0; i < 5; i++) w[i] = DATA_W'($urandom);
        write_word(w[0]);
        wait_start("burst", 4);
        fork
            expect_frame(w[0], pt, st, div_for(br), "burst0");
            begin
                for (int i = 1; i < 5; i++) write_word(w[i]);
            end
        join
        for (int i = 1; i < 5; i++) expect_frame(w[i], pt, st, div_for(br), $sformatf("burst%0d", i));
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] w0;
        logic [DATA_W-1:0] q[$];
        parity_type = 2'b00; baud_rate = 2'b10; stop_bits = 1'b0;
        w0 = DATA_W'($urandom);
        write_word(w0);
        wait_start("ovf", 4);
        fork
            expect_frame(w0, 2'b00, 1'b0, div_for(2'b10), "ovf_w0");
            begin
                logic [DATA_W-1:0] d;
                logic dropped;
                for (int i = 0; i < DEPTH + 1; i++) begin
                    d = DATA_W'($urandom);
                    dropped = (q.size() == DEPTH);
                    if (!dropped) q.push_back(d);
                    wr_data = d;
                    wr_en   = 1'b1;
                    @(negedge clk);
                    vectors++;
                    if (overflow !== dropped) begin
                        miscompares++;
                        $display("FAIL ovf_pulse_w%0d: overflow=%b, expected %b", i, overflow, dropped);
                    end
                end
                wr_en = 1'b0;
                @(negedge clk);
                vectors++;
                if (overflow !== 1'b0 || full !== 1'b1 || level !== LVL_W'(DEPTH) || empty !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_full_state: overflow=%b full=%b level=%0d empty=%b, expected 0 1 %0d 0",
                             overflow, full, level, empty, DEPTH);
                end
            end
        join
        vectors++;
        if (level !== LVL_W'(DEPTH - 1) || full !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_level_after_pop: level=%0d full=%b, expected %0d 0", level, full, DEPTH - 1);
        end
        for (int i = 0; i < DEPTH; i++) expect_frame(q[i], 2'b00, 1'b0, div_for(2'b10), $sformatf("ovf_q%0d", i));
        vectors++;
        if (tx !== 1'b1 || empty !== 1'b1 || tx_active_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_drain_idle: tx=%b empty=%b active=%b, expected 1 1 0", tx, empty, tx_active_flag);
        end
    endtask

    task automatic test_baud_change();
        logic [DATA_W-1:0] w1, w2;
        w1 = DATA_W'($urandom); w2 = DATA_W'($urandom);
        parity_type = 2'b00; baud_rate = 2'b10; stop_bits = 1'b0;
        write_word(w1);
        write_word(w2);
        wait_start("baud", 8);
        fork
            expect_frame(w1, 2'b00, 1'b0, div_for(2'b10), "baud_old");
            begin
                repeat (50) @(negedge clk);
                baud_rate = 2'b11;
            end
        join
        expect_frame(w2, 2'b00, 1'b0, div_for(2'b11), "baud_new");
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        int n;
        logic side, bad;
        logic [DATA_W-1:0] d;
        parity_type = 2'b00; baud_rate = 2'b10; stop_bits = 1'b0;
        break_req = 1'b1;
        @(negedge clk);
        break_req = 1'b0;
        n = 0; side = 1'b0;
        while (tx === 1'b0 && n < 2000) begin
            if (tx_active_flag !== 1'b0 || tx_done_flag !== 1'b0 || level !== '0) side = 1'b1;
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 2 * 10 * div_for(2'b10)) begin
            miscompares++;
            $display("FAIL break_low_len: %0d cycles, expected %0d", n, 2 * 10 * div_for(2'b10));
        end
        bad = 1'b0;
        for (int c = 0; c < div_for(2'b10); c++) begin
            if (tx !== 1'b1 || tx_active_flag !== 1'b0 || tx_done_flag !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (side || bad) begin
            miscompares++;
            $display("FAIL break_side_effects: during_low=%b during_high=%b, expected 0 0", side, bad);
        end
        d = DATA_W'($urandom);
        write_word(d);
        @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL break_return_idle: tx=%b two cycles after write, expected 0", tx);
        end
        expect_frame(d, 2'b00, 1'b0, div_for(2'b10), "after_break");
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic bad;
        parity_type = 2'b00; baud_rate = 2'b10; stop_bits = 1'b0;
        write_word(DATA_W'($urandom));
        write_word(DATA_W'($urandom));
        write_word(DATA_W'($urandom));
        wait_start("rst_mid", 8);
        repeat (50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || level !== '0 || empty !== 1'b1 || tx_active_flag !== 1'b0 || tx_done_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_immediate: tx=%b level=%0d empty=%b active=%b done=%b, expected 1 0 1 0 0",
                     tx, level, empty, tx_active_flag, tx_done_flag);
        end
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (tx_done_flag !== 1'b0 || tx !== 1'b1) bad = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_done_flag !== 1'b0 || tx_active_flag !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: line activity seen after reset, expected idle line and no done pulse");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        parity_type = 2'b00;
        baud_rate   = 2'b00;
        stop_bits   = 1'b0;
`ifdef UART_TX_BREAK_EN
        break_req   = 1'b0;
`endif
        test_reset();
        test_single_frame();
        test_random_frames();
        test_back_to_back();
        test_overflow();
        test_baud_change();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
